// File: rtl/multi_and_detector_pkg.sv
// multi_and_detector_pkg
//   Shared constants and helpers for the multi_and_detector block.
//   - DEF_* : default parameter values for the top level
//   - cnt_sat() : all-ones saturation value for a counter of a given width
package multi_and_detector_pkg;

    localparam int unsigned DEF_CHANNELS = 2;
    localparam int unsigned DEF_INPUTS   = 4;
    localparam int unsigned DEF_DELAY    = 1;
    localparam int unsigned DEF_CNT_W    = 8;

    // Largest value a w-bit unsigned counter can hold; clamps at 64 bits.
    function automatic logic [63:0] cnt_sat(input int unsigned w);
        if (w >= 64) begin
            return '1;
        end
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/and_match_channel.sv
// and_match_channel
//   One decoder channel: masked AND match, programmable delay line,
//   rising-edge pulse register and saturating hit counter.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   en       : advance the delay line; low freezes it and blanks y_rise
//   clr      : synchronous clear of the hit counter (independent of en)
//   din      : channel inputs
//   inv_mask : per-bit invert applied to din before the AND
//   y        : delayed match (last delay stage)
//   y_rise   : one-cycle pulse when y goes 0->1
//   hit_cnt  : saturating count of y_rise pulses
module and_match_channel
    import multi_and_detector_pkg::*;
#(
    parameter int unsigned INPUTS       = DEF_INPUTS,
    parameter int unsigned DELAY_CYCLES = DEF_DELAY,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [INPUTS-1:0] din,
    input  logic [INPUTS-1:0] inv_mask,
    output logic              y,
    output logic              y_rise,
    output logic [CNT_W-1:0]  hit_cnt
);

    localparam logic [CNT_W-1:0] CntSat = CNT_W'(cnt_sat(CNT_W));

    logic                    match;
    logic [DELAY_CYCLES-1:0] stage_q, stage_d;
    logic                    rise_q, rise_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    assign match = &(din ^ inv_mask);

    // stage_q[0] is the newest sample, stage_q[DELAY_CYCLES-1] drives y.
    if (DELAY_CYCLES == 1) begin : g_delay_one
        assign stage_d = match;
    end else begin : g_delay_multi
        assign stage_d = {stage_q[DELAY_CYCLES-2:0], match};
    end

    // Frozen edges force the pulse low so a held 1 never re-triggers.
    assign rise_d = en & stage_d[DELAY_CYCLES-1] & ~stage_q[DELAY_CYCLES-1];

    // Counts on any edge where the pulse is high, so a pulse that is
    // followed immediately by a freeze is still counted. clr wins.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (rise_q && (cnt_q != CntSat)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (en) begin
                stage_q <= stage_d;
            end
            rise_q <= rise_d;
            cnt_q  <= cnt_d;
        end
    end

    assign y       = stage_q[DELAY_CYCLES-1];
    assign y_rise  = rise_q;
    assign hit_cnt = cnt_q;

endmodule

// File: rtl/multi_and_detector.sv
// multi_and_detector
//   CHANNELS independent INPUTS-wide masked AND decoders with delay,
//   rising-edge pulse and saturating hit counter. Pure bus slicing here.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   en        : pipeline advance enable
//   clr       : synchronous clear of all hit counters
//   din       : channel c at [c*INPUTS +: INPUTS]
//   inv_mask  : invert mask, same packing as din
//   y         : delayed AND result per channel
//   y_rise    : per-channel 0->1 pulse
//   hit_cnt   : channel c at [c*CNT_W +: CNT_W]
module multi_and_detector
    import multi_and_detector_pkg::*;
#(
    parameter int unsigned CHANNELS     = DEF_CHANNELS,
    parameter int unsigned INPUTS       = DEF_INPUTS,
    parameter int unsigned DELAY_CYCLES = DEF_DELAY,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clr,
    input  logic [CHANNELS*INPUTS-1:0]   din,
    input  logic [CHANNELS*INPUTS-1:0]   inv_mask,
    output logic [CHANNELS-1:0]          y,
    output logic [CHANNELS-1:0]          y_rise,
    output logic [CHANNELS*CNT_W-1:0]    hit_cnt
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        and_match_channel #(
            .INPUTS       (INPUTS),
            .DELAY_CYCLES (DELAY_CYCLES),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .clr      (clr),
            .din      (din[c*INPUTS +: INPUTS]),
            .inv_mask (inv_mask[c*INPUTS +: INPUTS]),
            .y        (y[c]),
            .y_rise   (y_rise[c]),
            .hit_cnt  (hit_cnt[c*CNT_W +: CNT_W])
        );
    end

endmodule
